// File: rtl/spike_pkg.sv
// Shared types and width helpers for the spike row encoder.
package spike_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int acc_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/spike_skew_line.sv
// Delays a {valid, spike} pair by DEPTH clock cycles; DEPTH = 0 passes through.
module spike_skew_line #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic valid,
    input  logic spike,
    output logic valid_dly,
    output logic spike_dly
);
    localparam int SZ = (DEPTH == 0) ? 1 : DEPTH;

    logic [1:0] sr [SZ];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < SZ; j++) sr[j] <= '0;
        end else begin
            sr[0] <= {valid, spike};
            for (int j = 1; j < SZ; j++) sr[j] <= sr[j-1];
        end
    end

    assign {valid_dly, spike_dly} = (DEPTH == 0) ? {valid, spike} : sr[SZ-1];

endmodule

// File: rtl/spike_row_encoder.sv
// Integrate-and-fire encoder: one activation vector per frame in,
// NUM_STEPS skewed spike timesteps per PE row out.
module spike_row_encoder
    import spike_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROWS   = 4,
    parameter int NUM_STEPS  = 16,
    parameter int THRESHOLD  = 256
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_act,
    output logic [NUM_ROWS-1:0]            out_row,
    output logic [NUM_ROWS-1:0]            out_valid,
    output logic                           frame_done
);
    localparam int SW  = cnt_width(NUM_STEPS);
    localparam int DCW = cnt_width(NUM_ROWS);
    localparam int AW  = acc_width(DATA_WIDTH);

    localparam logic [SW-1:0]         LAST_STEP  = SW'(NUM_STEPS - 1);
    localparam logic [DCW-1:0]        LAST_DRAIN = DCW'(NUM_ROWS - 1);
    localparam logic [DATA_WIDTH-1:0] TH         = DATA_WIDTH'(THRESHOLD);
    localparam logic [AW-1:0]         TH_ACC     = AW'(THRESHOLD);

    state_t         state, state_n;
    logic [SW-1:0]  step, step_n;
    logic [DCW-1:0] dcnt, dcnt_n;
    logic           accept;
    logic           running;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign running  = (state == RUN);

    always_comb begin
        state_n = state;
        step_n  = step;
        dcnt_n  = dcnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = RUN;
                    step_n  = '0;
                end
            end
            RUN: begin
                step_n = step + 1'b1;
                if (step == LAST_STEP) begin
                    state_n = DRAIN;
                    step_n  = '0;
                    dcnt_n  = '0;
                end
            end
            DRAIN: begin
                dcnt_n = dcnt + 1'b1;
                if (dcnt == LAST_DRAIN) begin
                    state_n = IDLE;
                    dcnt_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // frame_done is registered: it lands on the final DRAIN cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            step       <= '0;
            dcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            dcnt       <= dcnt_n;
            frame_done <= (state_n == DRAIN) && (dcnt_n == LAST_DRAIN);
        end
    end

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        logic [DATA_WIDTH-1:0] lane;
        logic [DATA_WIDTH-1:0] act_q;
        logic [AW-1:0]         acc_q;
        logic [AW-1:0]         acc_new;
        logic                  fire;
        logic                  spike_q;
        logic                  valid_q;

        assign lane    = in_act[i*DATA_WIDTH +: DATA_WIDTH];
        assign acc_new = acc_q + {1'b0, act_q};
        assign fire    = (acc_new >= TH_ACC);

        // Clipping keeps acc below 2*THRESHOLD, so AW bits never overflow.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                act_q   <= '0;
                acc_q   <= '0;
                spike_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                if (accept) begin
                    act_q <= (lane >= TH) ? TH : lane;
                    acc_q <= '0;
                end else if (running) begin
                    acc_q <= fire ? (acc_new - TH_ACC) : acc_new;
                end
                spike_q <= running && fire;
                valid_q <= running;
            end
        end

        spike_skew_line #(
            .DEPTH(i)
        ) u_skew (
            .clk      (clk),
            .rstn     (rstn),
            .valid    (valid_q),
            .spike    (spike_q),
            .valid_dly(out_valid[i]),
            .spike_dly(out_row[i])
        );
    end

endmodule

// File: doc/spike_row_encoder.md
# spike_row_encoder

Converts a vector of unsigned activations into integrate-and-fire spike trains that drive the row spike inputs of the spiking PE array. It accepts one activation vector per frame over a valid/ready handshake and emits NUM_STEPS timesteps of spikes per row. Outputs are diagonally skewed, one extra cycle per row, to match systolic wavefront timing. It sits between the activation buffer and row 0 of the spiking PE grid.

## Interface
- DATA_WIDTH, 16, width of each activation lane.
- NUM_ROWS, 4, number of PE rows driven; skew depth is NUM_ROWS-1.
- NUM_STEPS, 16, timesteps per frame; must be ≥1.
- THRESHOLD, 256, firing threshold; must satisfy 1 ≤ THRESHOLD ≤ 2^DATA_WIDTH-1.
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  reset, asynchronous and active-low.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  encoder idle and able to accept a vector.
- in_act  in  NUM_ROWS*DATA_WIDTH  unsigned activations; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_row  out  NUM_ROWS  spike per row; bit i connects to the in_row input of PE row i.
- out_valid  out  NUM_ROWS  bit i is high while row i carries a live timestep.
- frame_done  out  1  one-cycle pulse on the last live output cycle of a frame.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- in_ready = (state == IDLE). Nothing else is decoded combinationally to outputs.
- IDLE: when in_valid && in_ready, latch all lanes. Any lane ≥ THRESHOLD is clipped to THRESHOLD. Clear all accumulators to 0 and go to RUN.
- RUN: step counter k runs 0..NUM_STEPS-1. For each row: acc_new = acc + act.
  - If acc_new ≥ THRESHOLD: spike = 1 and acc ← acc_new − THRESHOLD.
  - Otherwise: spike = 0 and acc ← acc_new.
  - After k = NUM_STEPS-1, go to DRAIN.
- Accumulator width is DATA_WIDTH+1, unsigned. Because of the clip, acc < 2·THRESHOLD always holds, so no overflow or saturation logic is needed.
- Spike count per row per frame is floor(act·NUM_STEPS / THRESHOLD).
- DRAIN: lasts NUM_ROWS cycles to flush the output register and skew lines. frame_done pulses in the last DRAIN cycle, then the FSM returns to IDLE.
- Skew: row i spike and valid pass through i extra register stages. Row 0 has only the output register.
- in_valid is ignored outside IDLE. in_act may change freely after the handshake.
- Residual accumulator charge is discarded at frame end; no carry-over between frames.

## Timing
- Handshake accepted in cycle c. RUN occupies c+1..c+NUM_STEPS and DRAIN occupies c+NUM_STEPS+1..c+NUM_STEPS+NUM_ROWS.
- Step k of row i is visible on out_row[i]/out_valid[i] in cycle c+2+k+i.
- frame_done is high in cycle c+NUM_STEPS+NUM_ROWS, coincident with the last out_valid[NUM_ROWS-1].
- in_ready rises in cycle c+NUM_STEPS+NUM_ROWS+1. Back-to-back frames are therefore separated by exactly one IDLE cycle.
- Reset values: state IDLE, in_ready 1, out_row 0, out_valid 0, frame_done 0, all accumulators, latched activations and skew stages 0.
- Reset asserted mid-frame clears everything immediately. No partial spikes appear after rstn deasserts, and the frame is abandoned.
- act = 0 gives out_valid high for NUM_STEPS cycles with out_row never asserted.

## Structure
- Shared include/package (spike_pkg): FSM state encoding (IDLE/RUN/DRAIN), a clog2 function for the step-counter and drain-counter widths, and the accumulator width expression DATA_WIDTH+1.
- Sub-module spike_skew_line, parameterised by DEPTH: a delays a {valid, spike} pair. DEPTH = 0 is a pass-through. The top instantiates one per row with DEPTH = i.
- One row accumulator is instantiated per row in a generate loop.

## Test plan
- THRESHOLD=16, NUM_STEPS=16, all lanes act=4, handshake at cycle c -> row 0 spikes at c+5, c+9, c+13, c+17 (4 spikes). Row 3 shows the same pattern 3 cycles later. frame_done at c+20; in_ready high at c+21.
- act = {0, 16, 40, 8} with THRESHOLD=16 -> spike counts per row {0, 16 (every step, clipped), 16, 8}; row 3 spikes on odd steps only.
- in_valid held high continuously with varying in_act -> one vector is accepted per frame. Only the vector sampled at the in_ready cycle is used, and the gap between frames is exactly one cycle.
- rstn pulsed low at RUN step 5 -> all outputs are 0 during reset and in_ready is 1. The next accepted frame produces spike counts identical to a clean frame.
- NUM_ROWS=1, NUM_STEPS=1, act=THRESHOLD -> single spike 2 cycles after the handshake, with frame_done in the same cycle.
- Random activations over 200 frames -> per-row spike counts match floor(min(act,TH)·NUM_STEPS/TH), and out_valid[i] is exactly out_valid[0] delayed by i cycles.
